// File: rtl/cnn_frame_loader.sv
// Serial byte-stream loader for cnn_accelerator: fills the kernel and ifmap register
// buffers from a valid/ready stream, then holds the accelerator enable until it is done.
module cnn_frame_loader #(
    parameter int DATA_WIDTH  = 8,
    parameter int IFMAP_SIZE  = 28,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load_weights,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic [0:IFMAP_SIZE-1][0:IFMAP_SIZE-1][DATA_WIDTH-1:0]           cnn_ifmap,
    output logic signed [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0]  weights,
    output logic                  acc_en,
    input  logic                  acc_done,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int CNT_W = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;
    localparam logic [CNT_W-1:0] IF_LAST = CNT_W'(IFMAP_SIZE - 1);
    localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_IF, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
    logic             in_ready_q, acc_en_q;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;
    logic             hs, w_we, if_we;

    logic [0:IFMAP_SIZE-1][0:IFMAP_SIZE-1][DATA_WIDTH-1:0]          ifmap_q;
    logic signed [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] weights_q;

    assign hs = in_valid && in_ready_q;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_err_d  = frame_err_q;
        frame_done_d = 1'b0;
        w_we         = 1'b0;
        if_we        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    frame_err_d = 1'b0;
                    row_d       = '0;
                    col_d       = '0;
                    state_d     = load_weights ? LOAD_W : LOAD_IF;
                end
            end
            LOAD_W: begin
                if (hs) begin
                    // A kernel beat flagged as last is malformed and is dropped unwritten.
                    if (in_last) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        w_we = 1'b1;
                        if (col_q == K_LAST) begin
                            col_d = '0;
                            if (row_q == K_LAST) begin
                                row_d   = '0;
                                state_d = LOAD_IF;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            LOAD_IF: begin
                if (hs) begin
                    if_we = 1'b1;
                    if (col_q == IF_LAST && row_q == IF_LAST) begin
                        row_d = '0;
                        col_d = '0;
                        if (in_last) begin
                            state_d = RUN;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end else begin
                        if (in_last) begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                        end
                        if (col_q == IF_LAST) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                if (acc_done) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            in_ready_q   <= 1'b0;
            acc_en_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ifmap_q      <= '0;
            weights_q    <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            in_ready_q   <= (state_d == LOAD_W) || (state_d == LOAD_IF);
            acc_en_q     <= (state_d == RUN);
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            // Decoded per-entry write enables keep every index inside its array bounds.
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    if (w_we && row_q == CNT_W'(r) && col_q == CNT_W'(c)) begin
                        weights_q[r][c] <= in_data;
                    end
                end
            end
            for (int r = 0; r < IFMAP_SIZE; r++) begin
                for (int c = 0; c < IFMAP_SIZE; c++) begin
                    if (if_we && row_q == CNT_W'(r) && col_q == CNT_W'(c)) begin
                        ifmap_q[r][c] <= in_data;
                    end
                end
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign acc_en     = acc_en_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign cnn_ifmap  = ifmap_q;
    assign weights    = weights_q;

endmodule
